shiftreg_ctrl: RTL
==================

Name: shiftreg_ctrl

Overview:
Command sequencer for the addressable-tap shift register (CE/SI shift-in, SEL-indexed DO tap).
- Accepts LOAD and READ commands over a valid/ready interface.
- Drives the shift register's CE, SI and SEL pins to serialise a parallel word in, or to gather a run of taps into a parallel response word.
- Sits between a register/bus agent and one shift-register instance, which stays external to this block.

Parameters:
SELWIDTH, 5, tap-select width; shift-register depth DW = 2**SELWIDTH (localparam).
LW, 8, maximum word length in bits for one LOAD/READ command (1 <= LW <= DW).
LENW, $clog2(LW)+1, width of cmd_len (localparam).

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  reset, asynchronous, active-high.
cmd_valid  input  1  command offered.
cmd_ready  output  1  controller idle; command accepted when cmd_valid & cmd_ready at a rising edge.
cmd_op  input  2  2'b00 NOP, 2'b01 LOAD, 2'b10 READ, 2'b11 reserved (treated as NOP).
cmd_len  input  LENW  bit count n; 0 is legal; values > LW are clamped to LW.
cmd_addr  input  SELWIDTH  first tap index for READ; ignored otherwise.
cmd_data  input  LW  LOAD payload; ignored otherwise.
rsp_valid  output  1  READ result available.
rsp_ready  input  1  consumer accepts result.
rsp_data  output  LW  READ result.
sr_ce  output  1  to shift-register CE.
sr_si  output  1  to shift-register SI.
sr_sel  output  SELWIDTH  to shift-register SEL.
sr_do  input  1  from shift-register DO; combinational function of sr_sel.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async):
  - state=IDLE.
  - sr_ce=0, sr_si=0, sr_sel=0.
  - rsp_valid=0, rsp_data=0, internal bit counter=0.
  - The shift register has no reset; its contents are untouched by RST.
- Registered outputs: sr_ce, sr_si, sr_sel, rsp_valid, rsp_data. cmd_ready = (state==IDLE), so it reads 1 during reset. busy = ~cmd_ready.
- States:
  - IDLE: on accept, NOP/reserved or n==0 LOAD -> IDLE (no side effect, no response); LOAD -> LOAD; READ with n==0 -> RESP with rsp_data=0; READ -> READ.
  - LOAD: n consecutive cycles with sr_ce=1. sr_si carries cmd_data[n-1], cmd_data[n-2], ..., cmd_data[0] (MSB of the used field first). After completion, tap i holds cmd_data[i] for i<n, and old tap j has moved to j+n (bits beyond DW-1 are lost). -> IDLE.
  - READ: n cycles with sr_ce=0; sr_sel = (cmd_addr+k) mod DW for k=0..n-1. At the edge ending cycle k, sr_do is captured into rsp_data[k]. Bits n..LW-1 are 0. -> RESP.
  - RESP: rsp_valid=1; rsp_data held stable until rsp_ready. On the handshake edge rsp_valid->0 and state->IDLE.
- Latency (accept edge = cycle 0):
  - LOAD of n bits: sr_ce high in cycles 1..n; cmd_ready high again in cycle n+1.
  - READ of n bits: rsp_valid high from cycle n+1; cmd_ready high the cycle after the response handshake.
- sr_ce is 0 in every state except LOAD. Between LOAD bits, sr_ce never drops (no bubbles).
- Address wrap: sr_sel arithmetic is modulo DW; tap DW-1 is followed by tap 0.
- Register latching: cmd_len (after clamp), cmd_addr and cmd_data are latched at accept; later changes on the cmd_* inputs have no effect.
- Simultaneous events: cmd_valid while busy is ignored and the command stays pending.
- Reset mid-operation: outputs return to reset values immediately. Partially shifted LOAD bits remain in the shift register. No response is emitted for an interrupted READ.

Decomposition:
- Shared package shiftreg_pkg:
  - op encodings OP_NOP/OP_LOAD/OP_READ/OP_RSVD;
  - state enum IDLE/LOAD/READ/RESP;
  - a helper function for len clamping.
- No sub-module is required. The shift register is instantiated alongside this block by the integrator. A verification top wrapper pairs shiftreg_ctrl with one shift-register instance.

Test Plan (SELWIDTH=5, LW=8):
1. Reset, then LOAD n=8 data=0xA5 -> sr_ce high exactly cycles 1..8, sr_si=1,0,1,0,0,1,0,1, cmd_ready low 8 cycles; then READ addr=0 n=8 -> rsp_valid in cycle 9, rsp_data=0xA5.
2. LOAD 0xFF n=8, then LOAD 0x00 n=8 three times (0xFF now at taps 24..31); READ addr=28 n=8 -> sr_sel 28,29,30,31,0,1,2,3, rsp_data=0x0F (wrap check).
3. READ with rsp_ready low for 5 cycles while cmd_valid held with LOAD -> rsp_valid/rsp_data stable, sr_ce stays 0, LOAD accepted only the cycle after the rsp handshake.
4. READ n=0 -> rsp_valid in cycle 1, rsp_data=0x00. READ n=12 -> clamped: exactly 8 sel cycles. LOAD n=0 and op=2'b11 -> no sr_ce pulse, no response, cmd_ready back next cycle.
5. Assert RST asynchronously mid-LOAD of 0xE0 n=8 after 3 bits -> sr_ce drops without a clock edge, busy=0; after release, READ addr=0 n=3 -> rsp_data=0x07.
6. Change cmd_data/cmd_addr every cycle after accept of READ addr=5 n=4 -> sr_sel stays 5,6,7,8; result is unaffected.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared encodings and helpers for the shift-register command sequencer.
// Op codes, controller states and the command length clamp.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_READ = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        READ = 2'b10,
        RESP = 2'b11
    } state_e;

    // Requested bit counts above the word size are served as a full word.
    function automatic int unsigned clamp_len(input int unsigned n,
                                              input int unsigned lw);
        return (n > lw) ? lw : n;
    endfunction

endpackage

// File: rtl/shiftreg_ctrl.sv
// Command sequencer for an addressable-tap shift register.
// LOAD serialises a word in MSB-first; READ gathers a run of taps.
module shiftreg_ctrl
    import shiftreg_pkg::*;
#(
    parameter int  SELWIDTH = 5,
    parameter int  LW       = 8,
    localparam int DW       = 2 ** SELWIDTH,
    localparam int LENW     = $clog2(LW) + 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [LENW-1:0]     cmd_len,
    input  logic [SELWIDTH-1:0] cmd_addr,
    input  logic [LW-1:0]       cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [LW-1:0]       rsp_data,
    output logic                sr_ce,
    output logic                sr_si,
    output logic [SELWIDTH-1:0] sr_sel,
    input  logic                sr_do,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [LENW-1:0]     cnt_q, cnt_d;
    logic [LENW-1:0]     len_q, len_d;
    logic [LW-1:0]       data_q, data_d;
    logic                sr_ce_q, sr_ce_d;
    logic                sr_si_q, sr_si_d;
    logic [SELWIDTH-1:0] sr_sel_q, sr_sel_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [LW-1:0]       rsp_data_q, rsp_data_d;

    logic                accept;
    logic [LENW-1:0]     len_c;
    logic [LW-1:0]       aligned;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign len_c     = LENW'(clamp_len(32'(cmd_len), 32'(LW)));

    assign sr_ce     = sr_ce_q;
    assign sr_si     = sr_si_q;
    assign sr_sel    = sr_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    // Next-state and registered-output logic for the command sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        data_d      = data_q;
        sr_sel_d    = sr_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        sr_ce_d     = 1'b0;
        sr_si_d     = 1'b0;
        aligned     = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD && len_c != '0) begin
                        // Left-justify the used field so the MSB is
                        // always at the top of the shift buffer.
                        aligned = cmd_data << (LENW'(LW) - len_c);
                        sr_ce_d = 1'b1;
                        sr_si_d = aligned[LW-1];
                        data_d  = aligned << 1;
                        cnt_d   = len_c - LENW'(1);
                        state_d = LOAD;
                    end else if (cmd_op == OP_READ) begin
                        len_d      = len_c;
                        cnt_d      = '0;
                        sr_sel_d   = cmd_addr;
                        rsp_data_d = '0;
                        if (len_c == '0) begin
                            rsp_valid_d = 1'b1;
                            state_d     = RESP;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    sr_ce_d = 1'b1;
                    sr_si_d = data_q[LW-1];
                    data_d  = data_q << 1;
                    cnt_d   = cnt_q - LENW'(1);
                end
            end
            READ: begin
                rsp_data_d = rsp_data_q | (LW'(sr_do) << cnt_q);
                if (cnt_q == len_q - LENW'(1)) begin
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d    = cnt_q + LENW'(1);
                    sr_sel_d = SELWIDTH'((int'(sr_sel_q) + 1) % DW);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves the external shift register alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            sr_ce_q     <= 1'b0;
            sr_si_q     <= 1'b0;
            sr_sel_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            data_q      <= data_d;
            sr_ce_q     <= sr_ce_d;
            sr_si_q     <= sr_si_d;
            sr_sel_q    <= sr_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule
